// File: rtl/booth_algo.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock.
// Result appears on out after 34 edges from reset release and then holds.
module booth_algo #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     inputM,
    input  logic [WIDTH-1:0]     inputQ,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nx;
    logic [WIDTH-1:0] q_nx;
    logic             last;

    // A and M carry one guard bit so negating the most negative M is exact
    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_nx = {sum[WIDTH], sum[WIDTH:1]};
        q_nx = {sum[0], q[WIDTH-1:1]};
    end

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    m     <= {inputM[WIDTH-1], inputM};
                    q     <= inputQ;
                    a     <= '0;
                    q_1   <= 1'b0;
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a     <= a_nx;
                    q     <= q_nx;
                    q_1   <= q[0];
                    count <= count + 1'b1;
                    if (last) begin
                        out   <= {a_nx[WIDTH-1:0], q_nx};
                        state <= DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_algo.sv
// Directed-vector bench for booth_algo: latency, hold, operand
// isolation outside LOAD, and mid-run abort.
module tb_booth_algo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inputM = '0;
    logic [31:0] inputQ = '0;
    logic [63:0] out;

    int errors = 0;
    int checks = 0;

    booth_algo #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .inputM (inputM),
        .inputQ (inputQ),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reset, load operands, release, then track every edge up to 34.
    task automatic run_mult(input string tag, input logic [31:0] m,
                            input logic [31:0] q, input logic [63:0] exp,
                            input bit chk_lat);
        @(negedge clk);
        reset  = 1'b0;
        inputM = m;
        inputQ = q;
        #1;
        check({tag, "_rst_async"}, out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                inputM = 32'h1234_5678;
                inputQ = 32'h9ABC_DEF1;
            end
            if (chk_lat && i < 34)
                check($sformatf("%s_edge%0d", tag, i), out, 64'd0);
            if (i == 33)
                check({tag, "_pre"}, out, 64'd0);
        end
        check(tag, out, exp);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_hold"}, out, exp);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 64'd0);

        run_mult("m7q2", 32'd7, 32'd2, 64'd14, 1'b0);
        run_mult("n2n5", 32'hFFFF_FFFE, 32'hFFFF_FFFB, 64'd10, 1'b0);
        run_mult("n5p2", 32'hFFFF_FFFB, 32'd2,
                 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
        run_mult("zeroq", 32'hF000_00F5, 32'd0, 64'd0, 1'b0);
        run_mult("onexcf", 32'd1, 32'h0000_00CF, 64'd207, 1'b0);
        run_mult("n255p313", 32'hFFFF_FF01, 32'h0000_0139,
                 64'hFFFF_FFFF_FFFE_C839, 1'b0);
        run_mult("minmin", 32'h8000_0000, 32'h8000_0000,
                 64'h4000_0000_0000_0000, 1'b1);
        run_mult("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 64'h3FFF_FFFF_0000_0001, 1'b0);
        run_mult("minmax", 32'h8000_0000, 32'h7FFF_FFFF,
                 64'hC000_0000_8000_0000, 1'b0);
        run_mult("n1n1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);

        // Abort a 7*2 run at its 10th RUN cycle, then restart with 3*3.
        @(negedge clk);
        reset  = 1'b0;
        inputM = 32'd7;
        inputQ = 32'd2;
        #1;
        check("abort_clear_prev", out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_rst", out, 64'd0);
        inputM = 32'd3;
        inputQ = 32'd3;
        @(posedge clk);
        #1;
        check("abort_hold0", out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (33) @(posedge clk);
        #1;
        check("abort_pre", out, 64'd0);
        @(posedge clk);
        #1;
        check("abort_3x3", out, 64'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_algo.md
BOOTH_ALGO -- requirements
Module: booth_algo

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, operand width in bits; all widths below are stated for WIDTH=32.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The module SHALL have port inputM, input, 32 bits: multiplicand, signed two's complement.
REQ-005 The module SHALL have port inputQ, input, 32 bits: multiplier, signed two's complement.
REQ-006 The module SHALL have port out, output, 64 bits: registered signed product inputM*inputQ.

Function
REQ-007 The block SHALL be a sequential radix-2 Booth multiplier with FSM states IDLE, LOAD, RUN and DONE.
REQ-008 While reset=0, the block SHALL clear all state asynchronously: state=IDLE, A=0, Q=0, Q_1=0, M=0, count=0, out=0.
REQ-009 On the first rising edge with reset=1 in IDLE, the block SHALL go to LOAD.
REQ-010 In LOAD, the block SHALL capture M=sign-extended inputM (33 bits), Q=inputQ, A=0 (33 bits), Q_1=0, count=0, then go to RUN.
REQ-011 Each RUN cycle SHALL examine {Q[0],Q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged.
REQ-012 Each RUN cycle SHALL then arithmetic-shift {A,Q,Q_1} right by one bit, replicating A[32], and increment count.
REQ-013 After exactly 32 RUN iterations, the block SHALL load out={A[31:0],Q} and go to DONE.
REQ-014 A and M SHALL be 33 bits wide so that inputM=0x80000000 gives a correct product.
REQ-015 In DONE, the block SHALL hold out and all state constant until reset is asserted again.
REQ-016 out SHALL stay 0 during LOAD and RUN and change only on the DONE transition; no intermediate values SHALL be visible.
REQ-017 Latency SHALL be 34 rising clock edges from reset deassertion to valid out (1 IDLE->LOAD, 1 LOAD, 32 RUN).
REQ-018 inputM and inputQ SHALL be sampled only in LOAD; changes to them at any other time SHALL have no effect.
REQ-019 The result SHALL be the exact 64-bit two's-complement product for all operand pairs; no overflow is possible.
REQ-020 Operand pairs with zero, one, positive and negative values SHALL need no special-case logic.

Reset
REQ-021 Asserting reset in any state, including mid-RUN, SHALL abort the operation immediately and clear out to 0.
REQ-022 Deasserting reset SHALL start a new multiplication using the operands present in LOAD.
REQ-023 Back-to-back operations SHALL be separated only by a reset pulse of at least one clock period.

Verification
REQ-024 inputM=7, inputQ=2; release reset; wait 40 cycles -> out=14.
REQ-025 inputM=0xFFFFFFFE (-2), inputQ=0xFFFFFFFB (-5) -> out=10; swap to inputM=0xFFFFFFFB, inputQ=2 -> out=-10 (0xFFFFFFFFFFFFFFF6).
REQ-026 inputM=0xF00000F5, inputQ=0 -> out=0; inputM=1, inputQ=0xCF -> out=207.
REQ-027 inputM=0xFFFFFF01 (-255), inputQ=0x139 (313) -> out=-79815.
REQ-028 inputM=inputQ=0x80000000 -> out=0x4000000000000000; check out=0 at edges 1-33 and valid at edge 34.
REQ-029 Assert reset at cycle 10 of RUN, change operands to 3,3, release -> out=0 during reset, then out=9 after 34 edges.
